// File: rtl/buttoncount_pkg.sv
// ---------------------------------------------------------------------------
// buttoncount_pkg
// Shared constants and helpers for the button-hold cycle counter.
//   LED_WIDTH      : board LED / counter width
//   cnt_action_e   : the per-edge counter action, listed in priority order
//   decode_action  : maps (rst, en) onto the action taken at the next edge
// ---------------------------------------------------------------------------
package buttoncount_pkg;

  localparam int LED_WIDTH = 16;

  typedef enum logic [1:0] {
    ACT_CLEAR = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_HOLD  = 2'd2
  } cnt_action_e;

  // Clear dominates count; with neither request the register holds.
  function automatic cnt_action_e decode_action(input logic rst, input logic en);
    cnt_action_e act;
    if (rst) begin
      act = ACT_CLEAR;
    end else if (en) begin
      act = ACT_COUNT;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/buttoncount_up_counter.sv
// ---------------------------------------------------------------------------
// up_counter
// WIDTH-bit free-running up counter with synchronous clear and enable.
//   clk : rising-edge clock
//   rst : synchronous active-high clear, wins over en
//   en  : increment by one on this edge (wraps modulo 2^WIDTH)
//   q   : counter register, driven straight from the flop
// ---------------------------------------------------------------------------
module up_counter
  import buttoncount_pkg::*;
#(
  parameter int WIDTH = LED_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  cnt_action_e action;

  // Resolve clear/count/hold priority for the coming edge.
  always_comb begin
    action = decode_action(rst, en);
  end

  // Counter register; the add wraps naturally at 2^WIDTH with no saturation.
  always_ff @(posedge clk) begin
    case (action)
      ACT_CLEAR: q <= '0;
      ACT_COUNT: q <= q + WIDTH'(1);
      ACT_HOLD:  q <= q;
      default:   q <= '0;
    endcase
  end

endmodule

// File: rtl/buttoncount.sv
// ---------------------------------------------------------------------------
// buttoncount
// Board top: counts the clock cycles during which the up button is held and
// shows the running count on the LEDs. No synchronizer or debounce: buttons
// are sampled as-is, one count per rising edge while btnu is high.
//   clk  : system clock
//   btnc : synchronous active-high clear
//   btnu : count enable (level, per cycle)
//   led  : current count, taken directly from the counter register
// ---------------------------------------------------------------------------
module buttoncount
  import buttoncount_pkg::*;
#(
  parameter int WIDTH = LED_WIDTH
) (
  input  logic             clk,
  input  logic             btnc,
  input  logic             btnu,
  output logic [WIDTH-1:0] led
);

  up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk (clk),
    .rst (btnc),
    .en  (btnu),
    .q   (led)
  );

endmodule

// File: tb/tb_buttoncount.sv
// ---------------------------------------------------------------------------
// tb_buttoncount
// Directed bench for buttoncount: reset, hold, repeated presses, mid-run
// clear, clear/enable priority and wrap-around.
// ---------------------------------------------------------------------------
module tb_buttoncount;

  logic        clk;
  logic        btnc;
  logic        btnu;
  logic [15:0] led;

  int          checks;
  int          failures;
  logic [15:0] exp_cnt;
  int          sum;

  buttoncount #(
    .WIDTH (16)
  ) dut (
    .clk  (clk),
    .btnc (btnc),
    .btnu (btnu),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: led=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock: reference model steps on the rising edge using the values
  // driven before it, led is compared on the following falling edge.
  task automatic cycle(input bit do_chk, input string tag);
    @(posedge clk);
    if (btnc) exp_cnt = 16'd0;
    else if (btnu) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    if (do_chk) check(tag, led, exp_cnt);
  endtask

  task automatic presses(input int n, input string tag);
    int len;
    int idle;
    for (int p = 0; p < n; p++) begin
      len  = int'($urandom_range(20, 5));
      idle = int'($urandom_range(100, 25));
      btnu = 1'b1;
      for (int i = 0; i < len; i++) cycle(1'b1, tag);
      btnu = 1'b0;
      sum += len;
      for (int i = 0; i < idle; i++) cycle(1'b1, tag);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'd0;
    btnc     = 1'b1;
    btnu     = 1'b0;

    // Reset held for 8 edges, then released on a negedge.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, "");
      check("reset_hold", led, 16'd0);
    end
    btnc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, "");
      check("reset_release", led, 16'd0);
    end

    // Hold for exactly 10 edges, then idle 50 cycles.
    btnu = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b1, "hold_ramp");
    btnu = 1'b0;
    check("hold_reach10", led, 16'd10);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, "");
      check("hold_idle10", led, 16'd10);
    end

    // 11 presses of random length; total must equal summed held cycles.
    sum = 10;
    presses(11, "press_model");
    check("press_sum", led, 16'(sum));

    // Mid-run clear: zero on the very first edge, stays zero.
    btnc = 1'b1;
    cycle(1'b0, "");
    check("midrst_first", led, 16'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, "");
      check("midrst_hold", led, 16'd0);
    end
    btnc = 1'b0;
    sum  = 0;
    presses(17, "press2_model");
    check("press2_sum", led, 16'(sum));

    // Clear and enable together: clear wins, then counting resumes at 1.
    btnc = 1'b1;
    btnu = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, "");
      check("prio_both", led, 16'd0);
    end
    btnc = 1'b0;
    cycle(1'b0, "");
    check("prio_first", led, 16'd1);
    cycle(1'b0, "");
    check("prio_second", led, 16'd2);
    cycle(1'b0, "");
    check("prio_third", led, 16'd3);

    // Wrap: clear, hold 65535 edges, then two more.
    btnu = 1'b0;
    btnc = 1'b1;
    cycle(1'b0, "");
    check("wrap_clear", led, 16'd0);
    btnc = 1'b0;
    btnu = 1'b1;
    for (int i = 0; i < 65535; i++) cycle(1'b0, "");
    check("wrap_max", led, 16'hFFFF);
    check("wrap_max_model", led, exp_cnt);
    cycle(1'b0, "");
    check("wrap_zero", led, 16'h0000);
    cycle(1'b0, "");
    check("wrap_one", led, 16'h0001);
    btnu = 1'b0;
    cycle(1'b0, "");
    check("wrap_freeze", led, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buttoncount.md
Name: buttoncount

Overview:
- Top-level board block that counts the clock cycles during which the up button (btnu) is held, and shows the running count on the 16 board LEDs.
- The centre button (btnc) clears the count.
- Sits directly under the board pins with a single system clock; no other logic in the path.

Parameters:
- WIDTH, 16, counter and LED width in bits; the board build uses 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- btnc  input  1  synchronous, active-high reset; clears the count.
- btnu  input  1  count enable; level-sensitive, sampled every rising edge.
- led  output  WIDTH  current count value, driven directly from the count register.

Behaviour:
- Single WIDTH-bit unsigned register cnt; led = cnt combinationally, with no output pipeline.
- At each posedge clk, evaluated in priority order:
  - btnc=1: cnt <= 0.
  - btnc=0 and btnu=1: cnt <= cnt + 1, modulo 2^WIDTH.
  - otherwise: cnt holds.
- Reset:
  - Synchronous and active-high; btnc has no asynchronous effect.
  - led=0 from the first posedge at which btnc is sampled high, and stays 0 while btnc remains high.
- Simultaneous btnc=1 and btnu=1: reset wins, so cnt=0.
- Counting is per cycle, not per press:
  - Holding btnu for N consecutive rising edges adds exactly N.
  - There is no edge detection, debounce or synchronizer stage.
  - Inputs are sampled as-is, so latency from btnu to led change is one clock edge.
- Release: when btnu drops, the count freezes at its last value until btnu rises again or btnc is asserted.
- Wrap-around: 2^WIDTH-1 plus one increment gives 0, with no saturation and no flag.
- Power-up:
  - Register initialised to 0 where the target supports it.
  - Correct operation is only required after the first btnc assertion.
  - Before that, led may be unknown in simulation.
- Reset mid-count: btnc asserted while btnu is held clears to 0 that edge.
  - While btnc is held, led stays 0.
  - If btnu is still high on the first edge after btnc drops, led becomes 1.
- No X-propagation tolerance required on btnu before the first reset; the environment drives btnu=0 before releasing reset.

Decomposition:
- Shared package buttoncount_pkg holds:
  - localparam LED_WIDTH = 16;
  - the enumerated priority order as a comment-free constant set, if the team needs it for checkers.
- One natural sub-module, up_counter, owning the register and all arithmetic:
  - Parameterised WIDTH.
  - Ports clk, rst, en, q.
  - Synchronous reset with priority over en.
- The top maps the ports: btnc to rst, btnu to en, q to led.

Test Plan:
- Reset: drive btnc=1 for 8 cycles with btnu=0, release on a negedge -> led=0 throughout and after release.
- Hold count: btnu=1 for exactly 10 rising edges, then 0 for 50 cycles -> led reaches 10 and holds at 10 for all 50 cycles.
- Repeated presses: 11 presses of random length 5–20 cycles, separated by 25–100 idle cycles -> led equals the sum of held cycles; a cycle-accurate reference model matches on every change.
- Mid-run reset: after the presses above, btnc=1 for 8 cycles -> led=0 on the first edge.
  - Then 17 more random presses -> count restarts from 0 and matches the model.
- Priority: btnc=1 and btnu=1 together for 5 cycles -> led=0.
  - Drop btnc with btnu still high -> led=1 on the next edge, then 2, 3, ...
- Wrap: hold btnu for 65535 edges -> led=0xFFFF.
  - One more edge -> led=0x0000.
  - One more -> 0x0001.
